// File: rtl/vga_scan_out_if.sv
// Compositor-facing bus of vga_scan_out: scan position/strobes out, pixel colour back in.
// With VGA_TEST_PATTERN_EN defined the bus also carries test_mode.
interface vga_scan_out_if;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        valid;
  logic        pixel_tick;
  logic        frame_start;
  logic [11:0] rgb_in;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_mode;

  modport master (
    output h_cnt, v_cnt, valid, pixel_tick, frame_start,
    input  rgb_in, test_mode
  );

  modport slave (
    input  h_cnt, v_cnt, valid, pixel_tick, frame_start,
    output rgb_in, test_mode
  );
`else
  modport master (
    output h_cnt, v_cnt, valid, pixel_tick, frame_start,
    input  rgb_in
  );

  modport slave (
    input  h_cnt, v_cnt, valid, pixel_tick, frame_start,
    output rgb_in
  );
`endif
endinterface

// File: rtl/vga_scan_out.sv
// VGA scan generator: pixel divider, h/v counters, registered RGB/sync pins one tick behind.
// Optional 8-bar test pattern when VGA_TEST_PATTERN_EN is defined.
module vga_scan_out #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_scan_out_if.master scan_if,
  output logic [3:0]     vga_r_o,
  output logic [3:0]     vga_g_o,
  output logic [3:0]     vga_b_o,
  output logic           hsync_o,
  output logic           vsync_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_start_q, frame_start_d;

  logic             tick;
  logic             h_last;
  logic             v_last;
  logic             active;
  logic [11:0]      pix_colour;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  logic [9:0]  bar_idx;
  logic [11:0] bar_colour;

  // Only meaningful while active, where h_cnt < H_ACTIVE keeps the index in 0..7.
  always_comb begin
    bar_idx = h_q / BAR_W;
    case (bar_idx)
      10'd0:   bar_colour = 12'hFFF;
      10'd1:   bar_colour = 12'hFF0;
      10'd2:   bar_colour = 12'h0FF;
      10'd3:   bar_colour = 12'h0F0;
      10'd4:   bar_colour = 12'hF0F;
      10'd5:   bar_colour = 12'hF00;
      10'd6:   bar_colour = 12'h00F;
      default: bar_colour = 12'h000;
    endcase
  end

  assign pix_colour = scan_if.test_mode ? bar_colour : scan_if.rgb_in;
`else
  assign pix_colour = scan_if.rgb_in;
`endif

  always_comb begin
    tick   = (div_q == DIV_LAST);
    h_last = (h_q == H_LAST);
    v_last = (v_q == V_LAST);
    active = (h_q < H_ACT) && (v_q < V_ACT);

    div_d         = tick ? '0 : div_q + 1'b1;
    h_d           = h_q;
    v_d           = v_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = tick && h_last && v_last;

    // Pins are computed from the position before the counters step, hence one tick of lag.
    if (tick) begin
      h_d     = h_last ? 10'd0 : h_q + 10'd1;
      if (h_last) begin
        v_d = v_last ? 10'd0 : v_q + 10'd1;
      end
      rgb_d   = active ? pix_colour : 12'h000;
      hsync_d = ~((h_q >= HS_FIRST) && (h_q <= HS_LAST));
      vsync_d = ~((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign scan_if.h_cnt       = h_q;
  assign scan_if.v_cnt       = v_q;
  assign scan_if.valid       = active;
  assign scan_if.pixel_tick  = tick;
  assign scan_if.frame_start = frame_start_q;

  assign vga_r_o = rgb_q[11:8];
  assign vga_g_o = rgb_q[7:4];
  assign vga_b_o = rgb_q[3:0];
  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: a shrunken-timing instance checked every clk against a position
// model, plus a default-timing instance for the 640x480 line timing numbers.
module tb_vga_scan_out;

  localparam int A_CD  = 2;
  localparam int A_HA  = 16;
  localparam int A_HFP = 2;
  localparam int A_HS  = 3;
  localparam int A_HBP = 3;
  localparam int A_VA  = 6;
  localparam int A_VFP = 1;
  localparam int A_VS  = 2;
  localparam int A_VBP = 1;
  localparam int A_HT  = A_HA + A_HFP + A_HS + A_HBP;
  localparam int A_VT  = A_VA + A_VFP + A_VS + A_VBP;
  localparam int A_FRAME = A_HT * A_VT;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  logic rgb_mode = 1'b0;
  logic tm_a = 1'b0;
  logic cmp_en = 1'b0;
  int   n_a = 0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       hs_a, vs_a, hs_b, vs_b;

  always #5 clk = ~clk;

  vga_scan_out_if if_a ();
  vga_scan_out_if if_b ();

  function automatic logic [11:0] rgb_fn(input int h, input int v);
    logic [3:0] hl, vl;
    hl = 4'(h);
    vl = 4'(v);
    return {hl, vl, hl ^ vl};
  endfunction

  assign if_a.rgb_in = rgb_mode ? rgb_fn(int'(if_a.h_cnt), int'(if_a.v_cnt)) : 12'hFDA;
  assign if_b.rgb_in = 12'hFDA;
`ifdef VGA_TEST_PATTERN_EN
  assign if_a.test_mode = tm_a;
  assign if_b.test_mode = 1'b0;
`endif

  vga_scan_out #(
    .CLK_DIV(A_CD), .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .scan_if(if_a.master),
    .vga_r_o(r_a), .vga_g_o(g_a), .vga_b_o(b_a), .hsync_o(hs_a), .vsync_o(vs_a)
  );

  vga_scan_out dut_b (
    .clk(clk), .rst_n(rst_n_b), .scan_if(if_b.master),
    .vga_r_o(r_b), .vga_g_o(g_b), .vga_b_o(b_b), .hsync_o(hs_b), .vsync_o(vs_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Colour the compositor side must have presented for pixel (h,v) of instance A.
  function automatic logic [11:0] model_colour(input int h, input int v);
    logic [11:0] pal [8];
    pal = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    if (tm_a) return pal[h / (A_HA / 8)];
    if (rgb_mode) return rgb_fn(h, v);
    return 12'hFDA;
  endfunction

  // Clocks since reset release; the whole scan state follows from this count.
  always @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) n_a <= 0;
    else          n_a <= n_a + 1;
  end

  always @(negedge clk) begin : model_cmp
    int n, k, pos, eh, ev, pp, ph, pv;
    logic [11:0] ec;
    logic ehs, evs;
    if (cmp_en) begin
      n   = n_a;
      k   = n / A_CD;
      pos = k % A_FRAME;
      eh  = pos % A_HT;
      ev  = pos / A_HT;
      if (k == 0) begin
        ec = 12'h000; ehs = 1'b1; evs = 1'b1;
      end else begin
        pp  = (k - 1) % A_FRAME;
        ph  = pp % A_HT;
        pv  = pp / A_HT;
        ec  = (ph < A_HA && pv < A_VA) ? model_colour(ph, pv) : 12'h000;
        ehs = !(ph >= A_HA + A_HFP && ph < A_HA + A_HFP + A_HS);
        evs = !(pv >= A_VA + A_VFP && pv < A_VA + A_VFP + A_VS);
      end
      check("a_h_cnt", int'(if_a.h_cnt), eh);
      check("a_v_cnt", int'(if_a.v_cnt), ev);
      check("a_valid", int'(if_a.valid), int'(eh < A_HA && ev < A_VA));
      check("a_pixel_tick", int'(if_a.pixel_tick), int'((n % A_CD) == A_CD - 1));
      check("a_frame_start", int'(if_a.frame_start), int'(k > 0 && (n % A_CD) == 0 && pos == 0));
      check("a_rgb", int'({r_a, g_a, b_a}), int'(ec));
      check("a_hsync", int'(hs_a), int'(ehs));
      check("a_vsync", int'(vs_a), int'(evs));
    end
  end

  // Returns at the negedge where A sits at (h,v) with pixel_tick high.
  task automatic wait_pos_a(input int h, input int v, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 1200 && !hit; i++) begin
      @(negedge clk);
      if (int'(if_a.h_cnt) == h && int'(if_a.v_cnt) == v && if_a.pixel_tick) hit = 1'b1;
    end
    check(tag, int'(hit), 1);
  endtask

  task automatic pins_after_tick_a(input int h, input int v, input logic [11:0] exp, input string tag);
    wait_pos_a(h, v, {tag, "_reach"});
    @(negedge clk);
    check(tag, int'({r_a, g_a, b_a}), int'(exp));
    $display("[A] pins after tick at (%0d,%0d): %03h", h, v, {r_a, g_a, b_a});
  endtask

  task automatic reset_a(input int cycles);
    rst_n_a = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n_a = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1 cmp_en = 1'b1;
    fork
      begin : seq_a
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("a_rst_h", int'(if_a.h_cnt), 0);
        check("a_rst_v", int'(if_a.v_cnt), 0);
        check("a_rst_valid", int'(if_a.valid), 1);
        check("a_rst_rgb", int'({r_a, g_a, b_a}), 0);
        check("a_rst_hsync", int'(hs_a), 1);
        check("a_rst_vsync", int'(vs_a), 1);
        check("a_rst_fs", int'(if_a.frame_start), 0);
        rst_n_a = 1'b1;
        $display("[A] reset released, constant FDA colour");
        pins_after_tick_a(0, 0, 12'hFDA, "a_fda_first");
        pins_after_tick_a(15, 0, 12'hFDA, "a_fda_last_active");
        pins_after_tick_a(16, 0, 12'h000, "a_hblank");
        pins_after_tick_a(5, 6, 12'h000, "a_vblank");
        repeat (600) @(posedge clk);

        wait_pos_a(10, 4, "a_mid_reach");
        check("a_mid_pre_rgb", int'({r_a, g_a, b_a}), 12'hFDA);
        #2 rst_n_a = 1'b0;
        #1;
        check("a_mid_h", int'(if_a.h_cnt), 0);
        check("a_mid_v", int'(if_a.v_cnt), 0);
        check("a_mid_rgb", int'({r_a, g_a, b_a}), 0);
        check("a_mid_hsync", int'(hs_a), 1);
        check("a_mid_vsync", int'(vs_a), 1);
        $display("[A] mid-frame reset at (10,4) applied");
        rgb_mode = 1'b1;
        reset_a(5);
        $display("[A] reset released, position-dependent colour");
        repeat (700) @(posedge clk);
`ifdef VGA_TEST_PATTERN_EN
        tm_a = 1'b1;
        reset_a(5);
        $display("[A] reset released, test pattern");
        pins_after_tick_a(0, 0, 12'hFFF, "a_bar0");
        pins_after_tick_a(3, 0, 12'hFF0, "a_bar1");
        pins_after_tick_a(15, 0, 12'h000, "a_bar7");
        pins_after_tick_a(20, 0, 12'h000, "a_bar_blank");
        repeat (500) @(posedge clk);
`endif
      end
      begin : seq_b
        int first, tclk, fall1, fall2, rise1, h_fall, nfall;
        logic prev_hs;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("b_rst_h", int'(if_b.h_cnt), 0);
        check("b_rst_v", int'(if_b.v_cnt), 0);
        check("b_rst_valid", int'(if_b.valid), 1);
        check("b_rst_hsync", int'(hs_b), 1);
        check("b_rst_fs", int'(if_b.frame_start), 0);
        check("b_rst_tick", int'(if_b.pixel_tick), 0);
        rst_n_b = 1'b1;
        first = 0;
        for (int j = 2; j <= 10; j++) begin
          @(negedge clk);
          if (first == 0 && if_b.pixel_tick) first = j;
        end
        check("b_first_tick_clk", first, 4);
        check("b_first_rgb", int'({r_b, g_b, b_b}), 12'hFDA);
        $display("[B] first pixel_tick in clk %0d after release", first);

        tclk = 0; fall1 = -1; fall2 = -1; rise1 = -1; h_fall = -1; nfall = 0;
        prev_hs = hs_b;
        while (tclk < 8000 && nfall < 2) begin
          @(negedge clk);
          tclk++;
          if (prev_hs && !hs_b) begin
            nfall++;
            if (nfall == 1) begin fall1 = tclk; h_fall = int'(if_b.h_cnt); end
            else fall2 = tclk;
          end
          if (!prev_hs && hs_b && rise1 < 0) rise1 = tclk;
          prev_hs = hs_b;
        end
        check("b_hsync_falls_seen", nfall, 2);
        check("b_hsync_period", fall2 - fall1, 3200);
        check("b_hsync_low", rise1 - fall1, 384);
        check("b_hsync_fall_hcnt", h_fall, 657);
        check("b_vsync_idle", int'(vs_b), 1);
        $display("[B] hsync period %0d clk, low %0d clk, h_cnt %0d at fall",
                 fall2 - fall1, rise1 - fall1, h_fall);
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
